data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory with a 16-entry direct-mapped read cache.
//   Read hits answer in 1 cycle; read misses and writes take WAIT_CYCLES+1.
//   Errors (out-of-range, misaligned, or read+write together) answer in 1 cycle.
// Ports
//   clk, reset      : rising-edge clock, async active-high reset
//   mem_read/write  : request strobes, held until ready
//   addr, wdata     : byte address (word index addr[9:2]) and write data
//   rdata           : registered read data, held between reads
//   ready, err      : one-cycle completion pulse, err valid with ready
//   hit_count/miss_count : saturating read hit/miss counters
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wcnt;
    logic            r_wr;
    logic [7:0]      r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_ready;
    logic            r_err;
    logic [15:0]     r_hit_count;
    logic [15:0]     r_miss_count;

    logic [31:0]     r_mem   [DEPTH];
    logic [15:0]     r_cvalid;
    logic [3:0]      r_ctag  [16];
    logic [31:0]     r_cdata [16];

    logic            w_acc;
    logic            w_err;
    logic            w_hit;
    logic            w_cmp;
    logic            w_c_wr;
    logic [7:0]      w_c_idx;
    logic [31:0]     w_c_wdata;
    logic            w_c_hit;

    assign w_acc = (r_state == IDLE) && (mem_read || mem_write);
    assign w_err = (addr[31:10] != 22'd0) || (addr[1:0] != 2'd0) || (mem_read && mem_write);
    assign w_hit = r_cvalid[addr[5:2]] && (r_ctag[addr[5:2]] == addr[9:6]);

    // Completion of a miss/write: end of WAIT, or straight from IDLE when
    // there are no wait cycles. Gated by reset so an abort never commits.
    assign w_cmp = !reset &&
                   (((r_state == WAIT) && (r_wcnt == '0)) ||
                    ((WAIT_CYCLES == 0) && w_acc && !w_err && (mem_write || !w_hit)));

    // Operands come from the latched request in WAIT, from the ports in IDLE.
    assign w_c_wr    = (r_state == WAIT) ? r_wr    : mem_write;
    assign w_c_idx   = (r_state == WAIT) ? r_idx   : addr[9:2];
    assign w_c_wdata = (r_state == WAIT) ? r_wdata : wdata;
    assign w_c_hit   = r_cvalid[w_c_idx[3:0]] && (r_ctag[w_c_idx[3:0]] == w_c_idx[7:4]);

    // Backing memory and cache payload are not reset.
    always_ff @(posedge clk) begin
        if (w_cmp && w_c_wr) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
        if (w_cmp && !w_c_wr) begin
            r_ctag[w_c_idx[3:0]]  <= w_c_idx[7:4];
            r_cdata[w_c_idx[3:0]] <= r_mem[w_c_idx];
        end else if (w_cmp && w_c_wr && w_c_hit) begin
            r_cdata[w_c_idx[3:0]] <= w_c_wdata;   // write-through, no allocate
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wcnt       <= '0;
            r_wr         <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_cvalid     <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (w_err) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else if (mem_read && w_hit) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_rdata <= r_cdata[addr[5:2]];
                            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
                        end else if (!w_cmp) begin
                            r_state <= WAIT;
                            r_wcnt  <= CW'(WAIT_CYCLES - 1);
                            r_wr    <= mem_write;
                            r_idx   <= addr[9:2];
                            r_wdata <= wdata;
                        end
                    end
                end
                WAIT: begin
                    if (r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_cmp) begin
                r_state <= RESP;
                r_ready <= 1'b1;
                if (!w_c_wr) begin
                    r_rdata             <= r_mem[w_c_idx];
                    r_cvalid[w_c_idx[3:0]] <= 1'b1;
                    if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
                end
            end
        end
    end

    assign rdata      = r_rdata;
    assign ready      = r_ready;
    assign err        = r_err;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [15:0] hit_count, miss_count;

    int n_chk = 0;
    int n_fail = 0;

    data_mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        e;
        logic [31:0] rdv;
        logic [15:0] hits;
        logic [15:0] miss;
    } vec_t;

    vec_t v[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request, return latency (edges from accept to ready sampled),
    // rdata and err seen with ready. Also checks that ready is a single pulse.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd_o, output logic e_o);
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        lat = 1;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ready) lat = 99;
        rd_o = rdata;
        e_o  = err;
        @(posedge clk); #1;
        chk("ready_single_pulse", {31'd0, ready}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] r;
        logic        e;
        logic        saw_ready;

        // rd wr addr wdata lat err rdata hits miss
        v[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 3, 1'b0, 32'h0,        16'd0, 16'd0};
        v[1]  = '{1'b1, 1'b0, 32'h010, 32'h0,        3, 1'b0, 32'hDEADBEEF, 16'd0, 16'd1};
        v[2]  = '{1'b1, 1'b0, 32'h010, 32'h0,        1, 1'b0, 32'hDEADBEEF, 16'd1, 16'd1};
        v[3]  = '{1'b0, 1'b1, 32'h004, 32'h11111111, 3, 1'b0, 32'hDEADBEEF, 16'd1, 16'd1};
        v[4]  = '{1'b0, 1'b1, 32'h044, 32'h22222222, 3, 1'b0, 32'hDEADBEEF, 16'd1, 16'd1};
        v[5]  = '{1'b1, 1'b0, 32'h004, 32'h0,        3, 1'b0, 32'h11111111, 16'd1, 16'd2};
        v[6]  = '{1'b1, 1'b0, 32'h044, 32'h0,        3, 1'b0, 32'h22222222, 16'd1, 16'd3};
        v[7]  = '{1'b1, 1'b0, 32'h004, 32'h0,        3, 1'b0, 32'h11111111, 16'd1, 16'd4};
        v[8]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1, 1'b1, 32'h0,        16'd1, 16'd4};
        v[9]  = '{1'b1, 1'b0, 32'h002, 32'h0,        1, 1'b1, 32'h0,        16'd1, 16'd4};
        v[10] = '{1'b1, 1'b1, 32'h010, 32'h55555555, 1, 1'b1, 32'h0,        16'd1, 16'd4};
        v[11] = '{1'b1, 1'b0, 32'h010, 32'h0,        1, 1'b0, 32'hDEADBEEF, 16'd2, 16'd4};
        v[12] = '{1'b0, 1'b1, 32'h020, 32'h0,        3, 1'b0, 32'hDEADBEEF, 16'd2, 16'd4};
        v[13] = '{1'b1, 1'b0, 32'h020, 32'h0,        3, 1'b0, 32'h0,        16'd2, 16'd5};
        v[14] = '{1'b0, 1'b1, 32'h020, 32'h12345678, 3, 1'b0, 32'h0,        16'd2, 16'd5};
        v[15] = '{1'b1, 1'b0, 32'h020, 32'h0,        1, 1'b0, 32'h12345678, 16'd3, 16'd5};
        v[16] = '{1'b0, 1'b1, 32'h060, 32'h33333333, 3, 1'b0, 32'h12345678, 16'd3, 16'd5};
        v[17] = '{1'b1, 1'b0, 32'h020, 32'h0,        1, 1'b0, 32'h12345678, 16'd4, 16'd5};

        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        reset = 1'b1;
        #23;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_hits",  {16'd0, hit_count},  32'd0);
        chk("rst_miss",  {16'd0, miss_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_req(v[i].rd, v[i].wr, v[i].a, v[i].d, lat, r, e);
            chk($sformatf("v%0d_lat", i),   lat, v[i].lat);
            chk($sformatf("v%0d_err", i),   {31'd0, e}, {31'd0, v[i].e});
            chk($sformatf("v%0d_rdata", i), r, v[i].rdv);
            chk($sformatf("v%0d_hits", i),  {16'd0, hit_count},  {16'd0, v[i].hits});
            chk($sformatf("v%0d_miss", i),  {16'd0, miss_count}, {16'd0, v[i].miss});
        end

        // Reset in WAIT aborts a pending write and clears the cache.
        do_req(1'b0, 1'b1, 32'h030, 32'h1, lat, r, e);
        chk("w30_lat", lat, 3);
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h030; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        mem_write = 1'b0;
        saw_ready = ready;
        @(posedge clk); #1;
        saw_ready |= ready;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            saw_ready |= ready;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            saw_ready |= ready;
        end
        chk("abort_no_ready", {31'd0, saw_ready}, 32'd0);
        chk("abort_hits", {16'd0, hit_count},  32'd0);
        chk("abort_miss", {16'd0, miss_count}, 32'd0);
        do_req(1'b1, 1'b0, 32'h030, 32'h0, lat, r, e);
        chk("r30_lat",   lat, 3);
        chk("r30_rdata", r, 32'h1);
        chk("r30_miss",  {16'd0, miss_count}, 32'd1);
        chk("r30_hits",  {16'd0, hit_count},  32'd0);

        // Hit counter saturation.
        @(negedge clk);
        force dut.r_hit_count = 16'hFFFE;
        #1;
        release dut.r_hit_count;
        for (int k = 0; k < 3; k++) begin
            do_req(1'b1, 1'b0, 32'h030, 32'h0, lat, r, e);
            chk($sformatf("sat%0d_lat", k), lat, 1);
            chk($sformatf("sat%0d_rdata", k), r, 32'h1);
            chk($sformatf("sat%0d_hits", k), {16'd0, hit_count}, 32'h0000FFFF);
        end
        chk("sat_miss", {16'd0, miss_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
